// File: rtl/if_stage_pkg.sv
// Shared widths, reset vector and FSM state type for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned TO_ID_DATA_WIDTH = 64;
  localparam int unsigned BR_DATA_WIDTH    = 33;
  localparam logic [31:0] RESET_PC         = 32'h1c00_0000;

  // REQ: request driven, awaiting addr_ok
  // WAIT: one read outstanding, awaiting data_ok
  // HOLD: instruction buffered for ID
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding SRAM-like fetch,
// one-entry output buffer toward ID, and wrong-path cancellation on redirect.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ID_allow_in,
  input  logic [BR_DATA_WIDTH-1:0]    br_data,
  output logic                        IF_to_ID_valid,
  output logic [TO_ID_DATA_WIDTH-1:0] to_ID_data,
  output logic                        inst_sram_req,
  output logic [31:0]                 inst_sram_addr,
  input  logic                        inst_sram_addr_ok,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata
);

  if_state_e                   state_q, state_d;
  logic [31:0]                 npc_q, npc_d;
  logic [31:0]                 pc_inflight_q, pc_inflight_d;
  logic [31:0]                 br_pend_q, br_pend_d;
  logic                        br_pend_vld_q, br_pend_vld_d;
  logic                        cancel_q, cancel_d;
  logic                        outstanding_q, outstanding_d;
  logic [TO_ID_DATA_WIDTH-1:0] buf_q, buf_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] fetch_pc;
  logic        req_raw;
  logic        handshake;
  logic        rsp_fire;

  // Request generation, next-state and datapath updates.
  always_comb begin
    br_taken  = br_data[BR_DATA_WIDTH-1];
    br_target = br_data[31:0];

    // A latched redirect wins over the sequential pc until a request carries it.
    fetch_pc = br_pend_vld_q ? br_pend_q : npc_q;

    req_raw = 1'b0;
    case (state_q)
      S_REQ:   req_raw = 1'b1;
      // Draining the buffer overlaps with the next request, unless ID is
      // redirecting us in the same cycle (that request would be wrong-path).
      S_HOLD:  req_raw = ID_allow_in & ~br_taken;
      default: req_raw = 1'b0;
    endcase

    inst_sram_req  = req_raw & resetn;
    inst_sram_addr = fetch_pc;
    handshake      = inst_sram_req & inst_sram_addr_ok;
    rsp_fire       = (state_q == S_WAIT) & inst_sram_data_ok & outstanding_q;

    state_d       = state_q;
    npc_d         = npc_q;
    pc_inflight_d = pc_inflight_q;
    br_pend_d     = br_pend_q;
    br_pend_vld_d = br_pend_vld_q;
    cancel_d      = cancel_q;
    outstanding_d = outstanding_q;
    buf_d         = buf_q;

    case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_fire) begin
          if (cancel_q | br_taken) begin
            state_d  = S_REQ;
            cancel_d = 1'b0;
          end else begin
            state_d = S_HOLD;
            buf_d   = {pc_inflight_q, inst_sram_rdata};
          end
        end else if (br_taken) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          state_d = S_REQ;
        end else if (ID_allow_in) begin
          state_d = handshake ? S_WAIT : S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (handshake) begin
      pc_inflight_d = fetch_pc;
      npc_d         = seq_pc(fetch_pc);
      br_pend_vld_d = 1'b0;
      outstanding_d = 1'b1;
      // Only reachable from REQ: the fetch just accepted is wrong-path.
      if (br_taken) begin
        cancel_d = 1'b1;
      end
    end

    if (rsp_fire) begin
      outstanding_d = 1'b0;
    end

    // A newer redirect always overwrites an unconsumed one.
    if (br_taken) begin
      br_pend_d     = br_target;
      br_pend_vld_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_REQ;
      npc_q         <= RESET_PC;
      pc_inflight_q <= '0;
      br_pend_q     <= '0;
      br_pend_vld_q <= 1'b0;
      cancel_q      <= 1'b0;
      outstanding_q <= 1'b0;
      buf_q         <= '0;
    end else begin
      state_q       <= state_d;
      npc_q         <= npc_d;
      pc_inflight_q <= pc_inflight_d;
      br_pend_q     <= br_pend_d;
      br_pend_vld_q <= br_pend_vld_d;
      cancel_q      <= cancel_d;
      outstanding_q <= outstanding_d;
      buf_q         <= buf_d;
    end
  end

  assign IF_to_ID_valid = (state_q == S_HOLD);
  assign to_ID_data     = buf_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: an in-bench SRAM responder plus expected
// address / instruction queues filled by each directed scenario.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                        clk;
  logic                        resetn;
  logic                        ID_allow_in;
  logic [BR_DATA_WIDTH-1:0]    br_data;
  logic                        IF_to_ID_valid;
  logic [TO_ID_DATA_WIDTH-1:0] to_ID_data;
  logic                        inst_sram_req;
  logic [31:0]                 inst_sram_addr;
  logic                        inst_sram_addr_ok;
  logic                        inst_sram_data_ok;
  logic [31:0]                 inst_sram_rdata;

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ID_allow_in       (ID_allow_in),
    .br_data           (br_data),
    .IF_to_ID_valid    (IF_to_ID_valid),
    .to_ID_data        (to_ID_data),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  localparam logic [31:0] T1 = 32'h1c00_0100;
  localparam logic [31:0] T2 = 32'h1c00_0200;
  localparam logic [31:0] T3 = 32'h1c00_0300;

  int unsigned n_vec;
  int unsigned n_err;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  // SRAM responder state
  bit          rsp_pend;
  int unsigned rsp_cnt;
  int unsigned rsp_lat;
  logic [31:0] rsp_addr;

  int unsigned cyc;
  int unsigned last_xfer;
  bit          have_last;
  bit          chk_rate;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0bad_f00d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input bit deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_inst_q.push_back({a, mk_inst(a)});
  endtask

  // One clock cycle: drive SRAM outputs, observe the DUT, advance.
  // Entered and left at posedge+1.
  task automatic step();
    bit          hs;
    bit          got_data;
    logic [31:0] sent;
    logic [31:0] ea;
    inst_sram_addr_ok = (exp_addr_q.size() != 0);
    if (rsp_pend && rsp_cnt == 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mk_inst(rsp_addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = '0;
    end
    #2;
    if (rsp_pend) check("no_req_while_outstanding", {63'd0, inst_sram_req}, 64'd0);
    hs   = inst_sram_req && inst_sram_addr_ok;
    sent = inst_sram_addr;
    if (hs) begin
      ea = exp_addr_q.pop_front();
      check("req_addr", {32'd0, sent}, {32'd0, ea});
    end
    if (IF_to_ID_valid && ID_allow_in && !br_data[BR_DATA_WIDTH-1]) begin
      check("xfer_expected", {63'd0, exp_inst_q.size() != 0}, 64'd1);
      if (exp_inst_q.size() != 0) check("to_ID_data", to_ID_data, exp_inst_q.pop_front());
      if (chk_rate && have_last) check("xfer_spacing", 64'(cyc - last_xfer), 64'd2);
      last_xfer = cyc;
      have_last = 1'b1;
    end
    got_data = inst_sram_data_ok;
    @(posedge clk);
    #1;
    cyc++;
    if (got_data) rsp_pend = 1'b0;
    if (hs) begin
      rsp_pend = 1'b1;
      rsp_addr = sent;
      rsp_cnt  = rsp_lat - 1;
    end else if (rsp_pend && rsp_cnt > 0) begin
      rsp_cnt--;
    end
  endtask

  task automatic run_until_empty(input int unsigned budget);
    int unsigned n = 0;
    while (exp_inst_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("inst_queue_drained", 64'(exp_inst_q.size()), 64'd0);
    check("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
    exp_inst_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    while (!IF_to_ID_valid && n < budget) begin
      step();
      n++;
    end
    check("hold_reached", {63'd0, IF_to_ID_valid}, 64'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_data = {1'b1, tgt};
    step();
    br_data = '0;
  endtask

  initial begin
    logic [63:0] held;
    n_vec = 0; n_err = 0; cyc = 0;
    rsp_pend = 1'b0; rsp_cnt = 0; rsp_lat = 1; rsp_addr = '0;
    have_last = 1'b0; chk_rate = 1'b0; last_xfer = 0;
    resetn = 1'b0; ID_allow_in = 1'b0; br_data = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;

    // Reset values
    #12;
    check("rst_req", {63'd0, inst_sram_req}, 64'd0);
    check("rst_valid", {63'd0, IF_to_ID_valid}, 64'd0);
    check("rst_to_ID_data", to_ID_data, 64'd0);
    resetn = 1'b1;
    #1;
    check("first_req", {63'd0, inst_sram_req}, 64'd1);
    check("first_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
    @(posedge clk);
    #1;

    // Sequential stream, one instruction every two cycles
    ID_allow_in = 1'b1;
    chk_rate = 1'b1;
    have_last = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push_fetch(RESET_PC + 32'(4 * i), 1'b1);
    run_until_empty(40);
    chk_rate = 1'b0;

    // ID stalls for five cycles in HOLD
    ID_allow_in = 1'b0;
    push_fetch(RESET_PC + 32'd20, 1'b1);
    wait_valid(20);
    held = {RESET_PC + 32'd20, mk_inst(RESET_PC + 32'd20)};
    for (int unsigned i = 0; i < 5; i++) begin
      check("stall_req", {63'd0, inst_sram_req}, 64'd0);
      check("stall_valid", {63'd0, IF_to_ID_valid}, 64'd1);
      check("stall_data", to_ID_data, held);
      step();
    end
    ID_allow_in = 1'b1;
    push_fetch(RESET_PC + 32'd24, 1'b1);
    run_until_empty(30);

    // Redirect while WAIT, data three cycles later is discarded
    rsp_lat = 4;
    push_fetch(RESET_PC + 32'd28, 1'b0);
    step();
    redirect(T1);
    rsp_lat = 1;
    push_fetch(T1, 1'b1);
    run_until_empty(30);

    // Redirect coinciding with addr_ok
    push_fetch(T1 + 32'd4, 1'b0);
    redirect(T2);
    push_fetch(T2, 1'b1);
    push_fetch(T2 + 32'd4, 1'b1);
    run_until_empty(30);

    // Redirect in HOLD with ID_allow_in=1 drops the buffered instruction
    ID_allow_in = 1'b0;
    push_fetch(T2 + 32'd8, 1'b0);
    wait_valid(20);
    ID_allow_in = 1'b1;
    redirect(T3);
    check("hold_redirect_valid", {63'd0, IF_to_ID_valid}, 64'd0);
    push_fetch(T3, 1'b1);
    run_until_empty(30);

    // Redirect in REQ without addr_ok, then wrap through 0xffff_fffc
    redirect(32'hffff_fff8);
    push_fetch(32'hffff_fff8, 1'b1);
    push_fetch(32'hffff_fffc, 1'b1);
    push_fetch(32'h0000_0000, 1'b1);
    push_fetch(32'h0000_0004, 1'b1);
    run_until_empty(40);

    // Reset asserted while a read is outstanding
    rsp_lat = 5;
    push_fetch(32'h0000_0008, 1'b0);
    step();
    step();
    resetn = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    rsp_pend = 1'b0;
    rsp_lat = 1;
    #1;
    check("midrst_req", {63'd0, inst_sram_req}, 64'd0);
    check("midrst_valid", {63'd0, IF_to_ID_valid}, 64'd0);
    check("midrst_to_ID_data", to_ID_data, 64'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check("midrst_first_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
    @(posedge clk);
    #1;
    push_fetch(RESET_PC, 1'b1);
    push_fetch(RESET_PC + 32'd4, 1'b1);
    run_until_empty(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
